// File: rtl/fixed_to_float_pkg.sv
// Shared IEEE-754 single-precision constants and field layout for the
// fixed-to-float converter.
package fixed_to_float_pkg;
  localparam int lp_BIAS      = 127;
  localparam int lp_EXP_WIDTH = 8;
  localparam int lp_MAN_WIDTH = 23;

  typedef struct packed {
    logic                    sign;
    logic [lp_EXP_WIDTH-1:0] exp;
    logic [lp_MAN_WIDTH-1:0] man;
  } float32_t;
endpackage

// File: rtl/leading_zero_counter.sv
// Leading-zero counter: counts zeros above the most significant one and
// flags an all-zero word (count equals the width in that case).
module leading_zero_counter #(
  parameter int p_WIDTH = 32,
  parameter int p_CNT_W = $clog2(p_WIDTH + 1)
) (
  input  logic [p_WIDTH-1:0] i_DATA,
  output logic [p_CNT_W-1:0] o_COUNT,
  output logic               o_ALL_ZERO
);
  localparam logic [p_CNT_W-1:0] lp_ONE = {{(p_CNT_W-1){1'b0}}, 1'b1};

  logic w_found;

  always_comb begin
    o_COUNT = '0;
    w_found = 1'b0;
    for (int i = p_WIDTH - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (i_DATA[i]) w_found = 1'b1;
        else           o_COUNT = o_COUNT + lp_ONE;
      end
    end
  end

  assign o_ALL_ZERO = !w_found;
endmodule

// File: rtl/fixed_to_float_rne.sv
// Fixed-point to IEEE-754 single converter, 3-stage valid/ready pipeline.
// Define FIXED_TO_FLOAT_ROUND_EN for round-to-nearest-even; otherwise truncate.
module fixed_to_float_rne
  import fixed_to_float_pkg::*;
#(
  parameter int p_IN_WIDTH  = 32,
  parameter int p_FRAC_BITS = 0,
  parameter int p_SIGNED    = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_VALID,
  output logic                  o_READY,
  input  logic [p_IN_WIDTH-1:0] i_FIXED_WORD,
  output logic                  o_VALID,
  input  logic                  i_READY,
  output logic [31:0]           o_FLOAT_WORD,
  output logic                  o_ZERO,
  output logic                  o_INEXACT
);
  localparam int lp_CNT_W   = $clog2(p_IN_WIDTH + 1);
  localparam int lp_EXT_W   = p_IN_WIDTH + lp_MAN_WIDTH + 2;
  localparam int lp_EXP_OFS = lp_BIAS + p_IN_WIDTH - 1 - p_FRAC_BITS;
`ifdef FIXED_TO_FLOAT_ROUND_EN
  localparam logic lp_RNE = 1'b1;
`else
  localparam logic lp_RNE = 1'b0;
`endif

  function automatic logic [lp_MAN_WIDTH:0] f_round(
    input logic [lp_MAN_WIDTH-1:0] man,
    input logic                    guard,
    input logic                    sticky
  );
    logic up;
    up = lp_RNE & guard & (sticky | man[0]);
    return {1'b0, man} + {{lp_MAN_WIDTH{1'b0}}, up};
  endfunction

  logic                    w_adv;
  logic                    w_sign;
  logic [p_IN_WIDTH-1:0]   w_mag;
  logic [lp_CNT_W-1:0]     w_lz;
  logic                    w_all_zero;
  logic [p_IN_WIDTH-1:0]   w_norm;
  logic [lp_EXP_WIDTH-1:0] w_exp;
  logic [lp_EXT_W-1:0]     w_ext;
  logic                    w_unused_lead;
  logic [lp_MAN_WIDTH-1:0] w_man;
  logic                    w_guard;
  logic                    w_sticky;
  logic [lp_MAN_WIDTH:0]   w_rnd;
  float32_t                w_res;

  logic                    r_vld_p0, r_vld_p1, r_vld_p2;
  logic                    r_sign_p0, r_sign_p1;
  logic [p_IN_WIDTH-1:0]   r_mag_p0;
  logic                    r_zero_p1;
  logic [lp_EXP_WIDTH-1:0] r_exp_p1;
  logic [p_IN_WIDTH-1:0]   r_norm_p1;
  logic [31:0]             r_word_p2;
  logic                    r_zero_p2;
  logic                    r_inexact_p2;

  // Whole pipeline advances together; bubbles travel rather than collapse.
  assign w_adv   = !(r_vld_p2 && !i_READY);
  assign o_READY = w_adv;

  // S1: sign and unsigned magnitude (most negative input stays exact)
  always_comb begin
    w_sign = (p_SIGNED != 0) && i_FIXED_WORD[p_IN_WIDTH-1];
    w_mag  = w_sign ? -i_FIXED_WORD : i_FIXED_WORD;
  end

  // S2: leading-zero count, normalise so the leading one sits at the MSB
  leading_zero_counter #(
    .p_WIDTH (p_IN_WIDTH),
    .p_CNT_W (lp_CNT_W)
  ) u_lzc (
    .i_DATA     (r_mag_p0),
    .o_COUNT    (w_lz),
    .o_ALL_ZERO (w_all_zero)
  );

  always_comb begin
    w_norm = r_mag_p0 << w_lz;
    w_exp  = lp_EXP_WIDTH'(lp_EXP_OFS - int'(w_lz));
  end

  // S3: extract mantissa/guard/sticky, round, pack
  always_comb begin
    w_ext         = {r_norm_p1, {(lp_MAN_WIDTH+2){1'b0}}};
    w_unused_lead = w_ext[lp_EXT_W-1];
    w_man         = w_ext[lp_EXT_W-2 -: lp_MAN_WIDTH];
    w_guard       = w_ext[lp_EXT_W-2-lp_MAN_WIDTH];
    w_sticky      = |w_ext[lp_EXT_W-3-lp_MAN_WIDTH:0];
    w_rnd         = f_round(w_man, w_guard, w_sticky);
    w_res.sign    = r_sign_p1;
    w_res.exp     = r_exp_p1 + lp_EXP_WIDTH'(w_rnd[lp_MAN_WIDTH]);
    w_res.man     = w_rnd[lp_MAN_WIDTH-1:0];
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_word_p2    <= '0;
      r_zero_p2    <= 1'b0;
      r_inexact_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p0 <= i_VALID;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_word_p2    <= r_zero_p1 ? '0 : w_res;
        r_zero_p2    <= r_zero_p1;
        r_inexact_p2 <= !r_zero_p1 && (w_guard || w_sticky);
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (w_adv && i_VALID) begin
      r_sign_p0 <= w_sign;
      r_mag_p0  <= w_mag;
    end
    if (w_adv && r_vld_p0) begin
      r_sign_p1 <= r_sign_p0;
      r_zero_p1 <= w_all_zero;
      r_exp_p1  <= w_exp;
      r_norm_p1 <= w_norm;
    end
  end

  assign o_VALID      = r_vld_p2;
  assign o_FLOAT_WORD = r_word_p2;
  assign o_ZERO       = r_zero_p2;
  assign o_INEXACT    = r_inexact_p2;
endmodule
